// File: rtl/bcd_counter_scanner.sv
// Four-digit BCD up/down counter with load clamping, one-cycle wrap pulse and a
// free-running digit scanner that drives active-low anodes and the selected nibble.
module bcd_counter_scanner #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value,
  output logic        carry,
  output logic        digit_w,
  output logic        digit_x,
  output logic        digit_y,
  output logic        digit_z,
  output logic [3:0]  an
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] value_q, value_d;
  logic        carry_q, carry_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  scan_idx_q, scan_idx_d;

  logic [15:0] load_clamped;
  logic [15:0] count_val;
  logic [4:0]  ripple;

  // ripple[i] is high when every digit below i sits at its wrap point (9 up, 0 down)
  assign ripple[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] ld_nib;
      logic [3:0] cur_nib;
      logic       at_edge;

      assign ld_nib  = load_val[gi*4 +: 4];
      assign cur_nib = value_q[gi*4 +: 4];
      assign at_edge = up ? (cur_nib == 4'd9) : (cur_nib == 4'd0);

      assign load_clamped[gi*4 +: 4] = (ld_nib > 4'd9) ? 4'd9 : ld_nib;
      assign ripple[gi+1] = ripple[gi] & at_edge;

      always_comb begin
        count_val[gi*4 +: 4] = cur_nib;
        if (ripple[gi]) begin
          if (up) count_val[gi*4 +: 4] = at_edge ? 4'd0 : cur_nib + 4'd1;
          else    count_val[gi*4 +: 4] = at_edge ? 4'd9 : cur_nib - 4'd1;
        end
      end
    end
  endgenerate

  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (load) begin
      value_d = load_clamped;
    end else if (cnt_en) begin
      value_d = count_val;
      carry_d = ripple[4];
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 16'd0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q    <= 16'h0000;
      carry_q    <= 1'b0;
      scan_cnt_q <= 16'd0;
      scan_idx_q <= 2'd0;
    end else begin
      value_q    <= value_d;
      carry_q    <= carry_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign value = value_q;
  assign carry = carry_q;
  assign an    = ~(4'b0001 << scan_idx_q);
  assign {digit_w, digit_x, digit_y, digit_z} = value_q[{scan_idx_q, 2'b00} +: 4];

endmodule

// File: tb/tb_bcd_counter_scanner.sv
// Self-checking bench: directed test-plan cases plus random stimulus, all checked
// every cycle against a decimal-integer reference model of counter and scanner.
module tb_bcd_counter_scanner;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst, cnt_en, up, load;
  logic [15:0] load_val;
  logic [15:0] value;
  logic        carry;
  logic        digit_w, digit_x, digit_y, digit_z;
  logic [3:0]  an;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: counter as a plain decimal integer, scan as elapsed cycles
  int m_val   = 0;
  int m_carry = 0;
  int m_cyc   = 0;

  bcd_counter_scanner #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .up(up), .load(load),
    .load_val(load_val), .value(value), .carry(carry),
    .digit_w(digit_w), .digit_x(digit_x), .digit_y(digit_y), .digit_z(digit_z),
    .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic int clamp_dec(input logic [15:0] v);
    int acc = 0;
    int w   = 1;
    for (int i = 0; i < 4; i++) begin
      int n = int'(v[i*4 +: 4]);
      if (n > 9) n = 9;
      acc += n * w;
      w   *= 10;
    end
    return acc;
  endfunction

  task automatic compare_all();
    int idx  = (m_cyc / SD) % 4;
    int dig  = (m_val / (idx == 0 ? 1 : idx == 1 ? 10 : idx == 2 ? 100 : 1000)) % 10;
    logic [3:0] an_exp = ~(4'b0001 << idx);
    chk("value", value, to_bcd(m_val));
    chk("carry", {15'd0, carry}, 16'(m_carry));
    chk("an", {12'd0, an}, {12'd0, an_exp});
    chk("digit", {12'd0, digit_w, digit_x, digit_y, digit_z}, 16'(dig));
  endtask

  // apply current inputs for one edge, advance the model, then compare
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_val = 0; m_carry = 0; m_cyc = 0;
    end else begin
      m_cyc++;
      m_carry = 0;
      if (load) m_val = clamp_dec(load_val);
      else if (cnt_en) begin
        if (up) begin
          if (m_val == 9999) begin m_val = 0; m_carry = 1; end
          else m_val++;
        end else begin
          if (m_val == 0) begin m_val = 9999; m_carry = 1; end
          else m_val--;
        end
      end
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic l, input logic [15:0] lv,
                       input logic c, input logic u);
    rst = r; load = l; load_val = lv; cnt_en = c; up = u;
    step();
  endtask

  initial begin
    rst = 1'b1; cnt_en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    step();
    drive(0, 0, 0, 0, 1);

    // reset mid-count from 0x0457, then watch the anodes rotate
    drive(0, 1, 16'h0457, 0, 1);
    drive(0, 0, 0, 1, 1);
    drive(1, 1, 16'h1234, 1, 1);
    drive(1, 0, 0, 1, 1);
    chk("rst_value", value, 16'h0000);
    chk("rst_an", {12'd0, an}, 16'h000E);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 0, 0, 1);
      if (i == 4)  chk("an_c4",  {12'd0, an}, 16'h000D);
      if (i == 8)  chk("an_c8",  {12'd0, an}, 16'h000B);
      if (i == 12) chk("an_c12", {12'd0, an}, 16'h0007);
      if (i == 16) chk("an_c16", {12'd0, an}, 16'h000E);
    end

    // up ripple and wrap
    drive(0, 1, 16'h0999, 0, 1);
    drive(0, 0, 0, 1, 1);
    chk("up_ripple", value, 16'h1000);
    drive(0, 1, 16'h9999, 0, 1);
    drive(0, 0, 0, 1, 1);
    chk("up_wrap", value, 16'h0000);
    chk("up_wrap_carry", {15'd0, carry}, 16'd1);
    drive(0, 0, 0, 0, 1);
    chk("up_carry_drop", {15'd0, carry}, 16'd0);

    // down borrow and wrap
    drive(0, 1, 16'h1000, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("dn_borrow", value, 16'h0999);
    drive(0, 1, 16'h0000, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("dn_wrap", value, 16'h9999);
    chk("dn_wrap_carry", {15'd0, carry}, 16'd1);
    drive(0, 0, 0, 0, 0);

    // load beats count, nibbles clamp to 9
    drive(0, 1, 16'hFA27, 1, 1);
    chk("load_clamp", value, 16'h9927);
    drive(0, 1, 16'h3AF2, 0, 1);
    chk("load_clamp2", value, 16'h3992);

    // scan/data consistency over a full scan period
    drive(0, 1, 16'h4321, 0, 1);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 1);

    // hold, then continuous count without carry
    drive(0, 1, 16'h0095, 0, 1);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1);
    chk("hold", value, 16'h0095);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 1);
    chk("cont_count", value, 16'h0107);

    // randomized traffic with wrap-prone loads mixed in
    for (int i = 0; i < 400; i++) begin
      logic [15:0] lv;
      int sel = int'($urandom_range(0, 3));
      lv = (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0000 : (sel == 2) ? 16'h9998 : 16'($urandom);
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10), lv,
            ($urandom_range(0, 99) < 70), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
